// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding,
// forwarding select codes, default counter width and the decode-source match.
// Latency: n/a (types and constants only). Backpressure: n/a.
package hazard_control_unit_pkg;

   typedef enum logic {
      RUN          = 1'b0,
      BR_LOAD_WAIT = 1'b1
   } hcu_state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int COUNT_WIDTH_DEFAULT = 16;

   // True when a later-stage destination feeds a source of the decode
   // instruction. Register 0 is hardwired and never creates a dependency.
   function automatic logic src_match(input logic [4:0] dest,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
      return (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle for the hazard unit: decode/execute/memory/writeback
// fields in, stall/flush/forward controls out.
// Latency: wires only. Backpressure: n/a; stalls are expressed as PCWrite/IFIDWrite.
interface hazard_control_unit_if;
   // decode stage
   logic [4:0] RSDecode;
   logic [4:0] RTDecode;
   logic       UsesRTDecode;
   logic       BranchDecode;
   logic       JumpDecode;
   logic       BranchTaken;
   // execute stage
   logic [4:0] RSExecute;
   logic [4:0] RTExecute;
   logic       RegWriteExecute;
   logic [1:0] MemReadExecute;
   logic [4:0] DestRegExecute;
   // memory stage
   logic       RegWriteMemory;
   logic [1:0] MemReadMemory;
   logic [4:0] DestRegMemory;
   // writeback stage
   logic       RegWriteWriteback;
   logic [4:0] DestRegWriteback;
   // controls back into the pipeline
   logic       PCWrite;
   logic       IFIDWrite;
   logic       IDEXFlush;
   logic       IFIDFlush;
   logic [1:0] ForwardA;
   logic [1:0] ForwardB;
   logic       ForwardBranchA;
   logic       ForwardBranchB;

   // master: the pipeline datapath; slave: the hazard unit
   modport master (
      output RSDecode, RTDecode, UsesRTDecode, BranchDecode, JumpDecode, BranchTaken,
             RSExecute, RTExecute, RegWriteExecute, MemReadExecute, DestRegExecute,
             RegWriteMemory, MemReadMemory, DestRegMemory,
             RegWriteWriteback, DestRegWriteback,
      input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush,
             ForwardA, ForwardB, ForwardBranchA, ForwardBranchB
   );

   modport slave (
      input  RSDecode, RTDecode, UsesRTDecode, BranchDecode, JumpDecode, BranchTaken,
             RSExecute, RTExecute, RegWriteExecute, MemReadExecute, DestRegExecute,
             RegWriteMemory, MemReadMemory, DestRegMemory,
             RegWriteWriteback, DestRegWriteback,
      output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush,
             ForwardA, ForwardB, ForwardBranchA, ForwardBranchB
   );
endinterface

// File: rtl/hazard_control_unit_forward_select.sv
// Execute-operand forwarding mux select for one source register.
// Latency: combinational. Backpressure: none.
// Ports: src (execute source reg), dest_mem/regwrite_mem, dest_wb/regwrite_wb, sel.
module forward_select
   import hazard_control_unit_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] dest_mem,
   input  logic       regwrite_mem,
   input  logic [4:0] dest_wb,
   input  logic       regwrite_wb,
   output logic [1:0] sel
);
   // The memory stage holds the younger result, so it wins over writeback.
   always_comb begin
      sel = FWD_REG;
      if (regwrite_mem && (dest_mem != 5'd0) && (dest_mem == src))
         sel = FWD_MEM;
      else if (regwrite_wb && (dest_wb != 5'd0) && (dest_wb == src))
         sel = FWD_WB;
   end
endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control: stall/bubble/flush for PC, IF/ID, ID/EX plus forwarding selects.
// Latency: zero -- controls are Mealy outputs valid in the cycle the hazard appears.
// Backpressure: stalls hold PC and IF/ID and bubble ID/EX; flush is suppressed while stalled.
// Ports: Clk, Reset (async active-low), hz (slave bundle), StallCycles, FlushCycles.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
)(
   input  logic                   Clk,
   input  logic                   Reset,
   hazard_control_unit_if.slave   hz,
   output logic [COUNT_WIDTH-1:0] StallCycles,
   output logic [COUNT_WIDTH-1:0] FlushCycles
);
   hcu_state_t state, state_nxt;
   logic       load_use, br_alu, br_load_mem;
   logic       stall, flush;

   assign load_use    = (hz.MemReadExecute != 2'b00) &&
                        src_match(hz.DestRegExecute, hz.RSDecode, hz.RTDecode, hz.UsesRTDecode);
   // An ALU result one stage ahead cannot reach the decode comparator in time.
   assign br_alu      = hz.BranchDecode && hz.RegWriteExecute && (hz.MemReadExecute == 2'b00) &&
                        src_match(hz.DestRegExecute, hz.RSDecode, hz.RTDecode, hz.UsesRTDecode);
   // Load data in memory stage is not available until writeback.
   assign br_load_mem = hz.BranchDecode && (hz.MemReadMemory != 2'b00) &&
                        src_match(hz.DestRegMemory, hz.RSDecode, hz.RTDecode, hz.UsesRTDecode);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= RUN;
      else        state <= state_nxt;
   end

   // A branch depending on a load in execute needs two bubbles; the second
   // is owed unconditionally via BR_LOAD_WAIT.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         RUN: begin
            stall = load_use || br_alu || br_load_mem;
            if (hz.BranchDecode && load_use) state_nxt = BR_LOAD_WAIT;
         end
         BR_LOAD_WAIT: begin
            stall     = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Stall wins over flush; a taken branch re-resolves once the stall clears.
   assign flush        = !stall && (hz.JumpDecode || (hz.BranchDecode && hz.BranchTaken));
   assign hz.PCWrite   = !stall;
   assign hz.IFIDWrite = !stall;
   assign hz.IDEXFlush = stall;
   assign hz.IFIDFlush = flush;

   assign hz.ForwardBranchA = hz.BranchDecode && hz.RegWriteMemory && (hz.MemReadMemory == 2'b00) &&
                              (hz.DestRegMemory != 5'd0) && (hz.DestRegMemory == hz.RSDecode);
   assign hz.ForwardBranchB = hz.BranchDecode && hz.RegWriteMemory && (hz.MemReadMemory == 2'b00) &&
                              (hz.DestRegMemory != 5'd0) && (hz.DestRegMemory == hz.RTDecode);

   forward_select u_fwd_a (
      .src          (hz.RSExecute),
      .dest_mem     (hz.DestRegMemory),
      .regwrite_mem (hz.RegWriteMemory),
      .dest_wb      (hz.DestRegWriteback),
      .regwrite_wb  (hz.RegWriteWriteback),
      .sel          (hz.ForwardA)
   );

   forward_select u_fwd_b (
      .src          (hz.RTExecute),
      .dest_mem     (hz.DestRegMemory),
      .regwrite_mem (hz.RegWriteMemory),
      .dest_wb      (hz.DestRegWriteback),
      .regwrite_wb  (hz.RegWriteWriteback),
      .sel          (hz.ForwardB)
   );

   // Saturating performance counters.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         StallCycles <= '0;
         FlushCycles <= '0;
      end else begin
         if (stall && !(&StallCycles)) StallCycles <= StallCycles + 1'b1;
         if (flush && !(&FlushCycles)) FlushCycles <= FlushCycles + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: driver computes expected outputs
// from a behavioural model and queues them; a negedge monitor pops and compares.
module tb_hazard_control_unit;
   localparam int CW     = 16;
   localparam int CNTMAX = (1 << CW) - 1;

   logic          Clk;
   logic          Reset;
   logic [CW-1:0] StallCycles, FlushCycles;

   hazard_control_unit_if hz ();

   hazard_control_unit #(.COUNT_WIDTH(CW)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .hz          (hz),
      .StallCycles (StallCycles),
      .FlushCycles (FlushCycles)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0] rsd, rtd;
      logic       ut, br, jmp, tk;
      logic [4:0] rse, rte;
      logic       rwe;
      logic [1:0] mre;
      logic [4:0] de;
      logic       rwm;
      logic [1:0] mrm;
      logic [4:0] dm;
      logic       rww;
      logic [4:0] dw;
   } stim_t;

   typedef struct {
      int pcw, ifidw, idexf, ifidf, fa, fb, fba, fbb, sc, fc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state: bubbles still owed, and counter values
   int   owed = 0;
   int   m_sc = 0;
   int   m_fc = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic bit dep(input logic [4:0] d, input stim_t s);
      return (d != 0) && (d == s.rsd || (s.ut && d == s.rtd));
   endfunction

   function automatic int fwd(input logic [4:0] src, input stim_t s);
      if (s.rwm && s.dm != 0 && s.dm == src) return 2;
      if (s.rww && s.dw != 0 && s.dw == src) return 1;
      return 0;
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Apply one cycle of inputs (and reset level), queue the expected response.
   task automatic drive(input stim_t s, input bit rst_n);
      exp_t e;
      bit   lu, hazard, stall, flush;
      @(posedge Clk);
      #1;
      Reset                = rst_n;
      hz.RSDecode          = s.rsd;  hz.RTDecode       = s.rtd;
      hz.UsesRTDecode      = s.ut;   hz.BranchDecode   = s.br;
      hz.JumpDecode        = s.jmp;  hz.BranchTaken    = s.tk;
      hz.RSExecute         = s.rse;  hz.RTExecute      = s.rte;
      hz.RegWriteExecute   = s.rwe;  hz.MemReadExecute = s.mre;
      hz.DestRegExecute    = s.de;
      hz.RegWriteMemory    = s.rwm;  hz.MemReadMemory  = s.mrm;
      hz.DestRegMemory     = s.dm;
      hz.RegWriteWriteback = s.rww;  hz.DestRegWriteback = s.dw;
      if (!rst_n) begin
         owed = 0; m_sc = 0; m_fc = 0;
      end
      lu     = (s.mre != 0) && dep(s.de, s);
      hazard = lu || (s.br && s.rwe && s.mre == 0 && dep(s.de, s))
                  || (s.br && s.mrm != 0 && dep(s.dm, s));
      stall  = (owed > 0) || hazard;
      flush  = !stall && (s.jmp || (s.br && s.tk));
      e.pcw   = !stall;
      e.ifidw = !stall;
      e.idexf = stall;
      e.ifidf = flush;
      e.fa    = fwd(s.rse, s);
      e.fb    = fwd(s.rte, s);
      e.fba   = s.br && s.rwm && s.mrm == 0 && s.dm != 0 && s.dm == s.rsd;
      e.fbb   = s.br && s.rwm && s.mrm == 0 && s.dm != 0 && s.dm == s.rtd;
      e.sc    = m_sc;
      e.fc    = m_fc;
      q.push_back(e);
      if (rst_n) begin
         if (stall && m_sc < CNTMAX) m_sc++;
         if (flush && m_fc < CNTMAX) m_fc++;
         // a branch that depends on a load in execute owes one more bubble
         if (owed > 0)             owed--;
         else if (s.br && lu)      owed = 1;
      end
   endtask

   always @(negedge Clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("PCWrite",        int'(hz.PCWrite),        e.pcw);
         chk("IFIDWrite",      int'(hz.IFIDWrite),      e.ifidw);
         chk("IDEXFlush",      int'(hz.IDEXFlush),      e.idexf);
         chk("IFIDFlush",      int'(hz.IFIDFlush),      e.ifidf);
         chk("ForwardA",       int'(hz.ForwardA),       e.fa);
         chk("ForwardB",       int'(hz.ForwardB),       e.fb);
         chk("ForwardBranchA", int'(hz.ForwardBranchA), e.fba);
         chk("ForwardBranchB", int'(hz.ForwardBranchB), e.fbb);
         chk("StallCycles",    int'(StallCycles),       e.sc);
         chk("FlushCycles",    int'(FlushCycles),       e.fc);
      end
   end

   initial begin
      stim_t s;
      Reset = 1'b0;
      s = idle();
      drive(s, 0);
      drive(s, 0);
      drive(s, 1);

      // load-use: lw $8 in execute, add $9,$8,$10 in decode
      s = idle(); s.mre = 2'b01; s.de = 8; s.rwe = 1; s.rsd = 8; s.rtd = 10; s.ut = 1;
      drive(s, 1);
      s.mre = 0; s.de = 0; s.rwe = 0; s.rwm = 1; s.mrm = 2'b01; s.dm = 8;
      drive(s, 1);
      drive(idle(), 1);

      // beq $8,$0 after lw $8: two bubbles then the flush
      s = idle(); s.mre = 2'b01; s.de = 8; s.rwe = 1; s.br = 1; s.tk = 1; s.rsd = 8; s.ut = 1;
      drive(s, 1);
      s.mre = 0; s.de = 0; s.rwe = 0; s.rwm = 1; s.mrm = 2'b01; s.dm = 8;
      drive(s, 1);
      s.rwm = 0; s.mrm = 0; s.dm = 0; s.rww = 1; s.dw = 8;
      drive(s, 1);
      drive(idle(), 1);

      // forwarding priority and register-0 rules
      s = idle(); s.rwm = 1; s.dm = 5; s.rww = 1; s.dw = 5; s.rse = 5;
      drive(s, 1);
      s.dm = 0;
      drive(s, 1);
      s.rte = 0; s.dw = 0;
      drive(s, 1);
      s = idle(); s.br = 1; s.rwm = 1; s.dm = 3; s.rsd = 3; s.rtd = 3;
      drive(s, 1);

      // jump with and without a load-use hazard
      s = idle(); s.jmp = 1;
      drive(s, 1);
      s.mre = 2'b10; s.de = 4; s.rsd = 4;
      drive(s, 1);

      // async reset asserted while owing the second bubble
      s = idle(); s.mre = 2'b01; s.de = 6; s.br = 1; s.rtd = 6; s.ut = 1;
      drive(s, 1);
      drive(idle(), 0);
      drive(idle(), 0);
      drive(idle(), 1);
      drive(idle(), 1);

      // randomized traffic over a small register range to provoke collisions
      for (int i = 0; i < 3000; i++) begin
         s.rsd = 5'($urandom_range(0, 3));  s.rtd = 5'($urandom_range(0, 3));
         s.ut  = 1'($urandom);  s.br = ($urandom_range(0, 2) == 0);
         s.jmp = ($urandom_range(0, 5) == 0);  s.tk = 1'($urandom);
         s.rse = 5'($urandom_range(0, 3));  s.rte = 5'($urandom_range(0, 3));
         s.rwe = 1'($urandom);
         s.mre = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         s.de  = 5'($urandom_range(0, 3));
         s.rwm = 1'($urandom);
         s.mrm = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         s.dm  = 5'($urandom_range(0, 3));
         s.rww = 1'($urandom);  s.dw = 5'($urandom_range(0, 3));
         drive(s, ($urandom_range(0, 199) != 0));
      end

      // saturation: hold a load-use hazard for more than 2^16 cycles
      drive(idle(), 0);
      s = idle(); s.mre = 2'b01; s.de = 7; s.rsd = 7;
      for (int i = 0; i < 70000; i++) drive(s, 1);
      drive(idle(), 1);
      drive(idle(), 1);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
